// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and a host preload/readback port.
// The CPU owns the port by default; the host gets idle cycles, or one forced stall cycle after STARVE losses.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wd,
    output logic [DATA_W-1:0] host_rd,
    output logic              host_ack,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic {H_WAIT, H_ACK} state_t;

    localparam logic [3:0] STARVE_C = 4'(STARVE);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       host_gnt;

    always_comb begin
        host_gnt     = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (state == H_WAIT) begin
            // rst_n gating keeps the port quiet while reset is held asynchronously
            host_gnt = rst_n & host_req & (~cpu_req | (wait_cnt == STARVE_C));
            if (host_gnt) begin
                state_nxt    = H_ACK;
                wait_cnt_nxt = 4'd0;
            end else if (!host_req) begin
                wait_cnt_nxt = 4'd0;
            end else if (wait_cnt != STARVE_C) begin
                wait_cnt_nxt = wait_cnt + 4'd1;
            end
        end else begin
            state_nxt    = H_WAIT;
            wait_cnt_nxt = 4'd0;
        end
    end

    assign mem_a     = host_gnt ? host_addr : cpu_addr;
    assign mem_wd    = host_gnt ? host_wd   : cpu_wd;
    assign mem_we    = rst_n & (host_gnt ? host_we : (cpu_req & cpu_we));
    assign cpu_stall = cpu_req & host_gnt;
    assign cpu_rd    = mem_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= H_WAIT;
            wait_cnt <= 4'd0;
            host_ack <= 1'b0;
            host_rd  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            host_ack <= host_gnt;
            if (host_gnt)
                host_rd <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem (combinational read, write on rising edge).
module tb_dmem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int STARVE = 4;

    logic              clk, rst_n;
    logic              cpu_req, cpu_we, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wd, cpu_rd;
    logic              host_req, host_we, host_ack;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wd, host_rd;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd, mem_rd;

    logic [DATA_W-1:0] dmem [0:1023];

    int vecs  = 0;
    int fails = 0;

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wd(host_wd),
        .host_rd(host_rd), .host_ack(host_ack),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rd = dmem[mem_a[9:0]];
    always @(posedge clk)
        if (mem_we) dmem[mem_a[9:0]] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0004; cpu_wd = 32'h0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wd = 32'hA5A5A5A5;

        // held in reset with both requesters active
        #2;
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        tick(); tick();
        chk("rst_ack2", 32'(host_ack), 32'd0);
        chk("rst_hrd", host_rd, 32'd0);
        chk("rst_we2", 32'(mem_we), 32'd0);

        // release with CPU idle: first cycle is a grant
        rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk("rel_gnt_we", 32'(mem_we), 32'd1);
        chk("rel_gnt_a", 32'(mem_a), 32'h0020);
        chk("rel_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("rel_ack", 32'(host_ack), 32'd1);
        chk("rel_mem", dmem[10'h020], 32'hA5A5A5A5);
        host_req = 1'b0;
        tick();
        chk("rel_ack_drop", 32'(host_ack), 32'd0);

        // idle CPU: host write then host read of 0x0100
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0100; host_wd = 32'hDEADBEEF;
        #1 chk("hw_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("hw_ack", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        tick();
        host_req = 1'b1; host_we = 1'b0; host_wd = 32'h0;
        #1 chk("hr_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("hr_ack", 32'(host_ack), 32'd1);
        chk("hr_data", host_rd, 32'hDEADBEEF);
        host_req = 1'b0;
        tick();

        // CPU busy every cycle: forced grant at N+STARVE
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0100;
        for (int k = 0; k < STARVE; k++) begin
            #1;
            chk($sformatf("st_stall%0d", k), 32'(cpu_stall), 32'd0);
            chk($sformatf("st_a%0d", k), 32'(mem_a), 32'h0005);
            tick();
        end
        #1;
        chk("st_stall_n4", 32'(cpu_stall), 32'd1);
        chk("st_a_n4", 32'(mem_a), 32'h0100);
        chk("st_ack_n4", 32'(host_ack), 32'd0);
        tick();
        chk("st_ack_n5", 32'(host_ack), 32'd1);
        chk("st_stall_n5", 32'(cpu_stall), 32'd0);
        chk("st_data", host_rd, 32'hDEADBEEF);
        host_req = 1'b0;
        tick();

        // stalled CPU store collides with forced host write to 0x0010
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wd = 32'h11111111;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wd = 32'h22222222;
        for (int k = 0; k < STARVE; k++) tick();
        #1 chk("col_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("col_mem_host", dmem[10'h010], 32'h22222222);
        chk("col_ack", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        tick();
        chk("col_mem_cpu", dmem[10'h010], 32'h11111111);
        cpu_req = 1'b0; cpu_we = 1'b0;

        // back-to-back host reads with req held high, CPU idle
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("b2b_ack%0d", k), 32'(host_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk($sformatf("b2b_rd%0d", k), host_rd, 32'hA5A5A5A5);
        end
        host_req = 1'b0;
        tick();

        // reset asserted in the forced grant cycle aborts the transaction
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wd = 32'h00000033;
        for (int k = 0; k < STARVE; k++) tick();
        #1 chk("rg_stall_pre", 32'(cpu_stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rg_we", 32'(mem_we), 32'd0);
        chk("rg_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("rg_ack", 32'(host_ack), 32'd0);
        rst_n = 1'b1;
        // wait_cnt must restart from 0: four more CPU-won cycles before the grant
        for (int k = 0; k < STARVE; k++) begin
            #1 chk($sformatf("rg_wait%0d", k), 32'(cpu_stall), 32'd0);
            chk($sformatf("rg_ack_w%0d", k), 32'(host_ack), 32'd0);
            tick();
        end
        #1 chk("rg_regrant", 32'(cpu_stall), 32'd1);
        tick();
        chk("rg_ack2", 32'(host_ack), 32'd1);
        chk("rg_mem", dmem[10'h030], 32'h00000033);
        host_req = 1'b0; cpu_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
